// File: rtl/ram_bus_arbiter_pkg.sv
// Shared types and constants for the serial-RAM bus arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package ram_bus_arbiter_pkg;

  localparam int ARB_STATE_WIDTH = 2;

  typedef enum logic [ARB_STATE_WIDTH-1:0] {
    ARB_STATE_IDLE      = 2'd0,
    ARB_STATE_GRANT_MCU = 2'd1,
    ARB_STATE_GRANT_COP = 2'd2,
    ARB_STATE_GUARD     = 2'd3
  } arb_state_t;

  // RAM mux select values, shared with the core-logic RAM mux
  localparam logic BUS_MODE_MCU = 1'b0;
  localparam logic BUS_MODE_COP = 1'b1;

  typedef enum logic {
    OWNER_MCU = 1'b0,
    OWNER_COP = 1'b1
  } owner_t;

endpackage

// File: rtl/ram_arb_sync.sv
// Parameterised-width 2-flop synchroniser with a synchronous reset value.
// Latency: 2 clk edges from input change to output.
// Backpressure: none; a free-running pipeline.
module ram_arb_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // two back-to-back flops; the first may go metastable, the second resolves it
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Arbitrates the shared serial-RAM SPI bus between the MCU and the coprocessor.
// Latency: 3 clk edges from request rise in IDLE to grant (2 sync + 1 decision).
// Backpressure: owner changes only while ram_nss is high; guard gap and max-hold revocation.
module ram_bus_arbiter #(
  parameter int GUARD_CYCLES = 4,
  parameter int MAX_HOLD     = 1024,
  parameter int HOLD_WIDTH   = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic mcu_req,
  input  logic cop_req,
  input  logic ram_nss_in,
  output logic bus_mode,
  output logic mcu_grant,
  output logic cop_grant,
  output logic bus_idle,
  output logic revoked
);

  import ram_bus_arbiter_pkg::*;

  localparam int                    GUARD_WIDTH = $clog2(GUARD_CYCLES + 1);
  localparam logic [GUARD_WIDTH-1:0] GUARD_LAST = GUARD_WIDTH'(GUARD_CYCLES - 1);
  localparam logic [HOLD_WIDTH-1:0]  HOLD_MAX   = HOLD_WIDTH'(MAX_HOLD);
  localparam logic                   REVOKE_EN  = (MAX_HOLD != 0);

  arb_state_t             state, state_nxt;
  owner_t                 last_owner, last_owner_nxt;
  logic                   bus_mode_nxt;
  logic                   revoked_nxt;
  logic [HOLD_WIDTH-1:0]  hold_cnt, hold_nxt;
  logic [GUARD_WIDTH-1:0] guard_cnt, guard_nxt;
  logic                   m, c, n;
  logic                   own_req, oth_req;

  // requests and chip select arrive asynchronously; idle values are reqs low, nss high
  ram_arb_sync #(
    .WIDTH     (3),
    .RESET_VAL (3'b001)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({mcu_req, cop_req, ram_nss_in}),
    .q     ({m, c, n})
  );

  // owner / contender requests seen from whichever side currently holds the bus
  assign own_req = (state == ARB_STATE_GRANT_COP) ? c : m;
  assign oth_req = (state == ARB_STATE_GRANT_COP) ? m : c;

  // next-state and datapath decisions; all owner changes gated by n (no frame open)
  always_comb begin
    state_nxt      = state;
    bus_mode_nxt   = bus_mode;
    last_owner_nxt = last_owner;
    hold_nxt       = hold_cnt;
    guard_nxt      = guard_cnt;
    revoked_nxt    = 1'b0;
    case (state)
      ARB_STATE_IDLE: begin
        if (n && (m || c)) begin
          hold_nxt = '0;
          if (m && (!c || last_owner == OWNER_COP)) begin
            state_nxt      = ARB_STATE_GRANT_MCU;
            bus_mode_nxt   = BUS_MODE_MCU;
            last_owner_nxt = OWNER_MCU;
          end else begin
            state_nxt      = ARB_STATE_GRANT_COP;
            bus_mode_nxt   = BUS_MODE_COP;
            last_owner_nxt = OWNER_COP;
          end
        end
      end
      ARB_STATE_GRANT_MCU, ARB_STATE_GRANT_COP: begin
        if (oth_req && hold_cnt != HOLD_MAX) begin
          hold_nxt = hold_cnt + 1'b1;
        end
        // a voluntary release takes priority over revocation in the same cycle
        if (n && !own_req) begin
          state_nxt = ARB_STATE_GUARD;
          guard_nxt = '0;
        end else if (n && REVOKE_EN && oth_req && hold_cnt == HOLD_MAX) begin
          state_nxt   = ARB_STATE_GUARD;
          guard_nxt   = '0;
          revoked_nxt = 1'b1;
        end
      end
      ARB_STATE_GUARD: begin
        if (guard_cnt == GUARD_LAST) begin
          state_nxt = ARB_STATE_IDLE;
        end else begin
          guard_nxt = guard_cnt + 1'b1;
        end
      end
      default: state_nxt = ARB_STATE_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= ARB_STATE_IDLE;
    else       state <= state_nxt;
  end

  // mux select, round-robin memory, counters and revoke pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_mode   <= BUS_MODE_MCU;
      last_owner <= OWNER_COP;
      hold_cnt   <= '0;
      guard_cnt  <= '0;
      revoked    <= 1'b0;
    end else begin
      bus_mode   <= bus_mode_nxt;
      last_owner <= last_owner_nxt;
      hold_cnt   <= hold_nxt;
      guard_cnt  <= guard_nxt;
      revoked    <= revoked_nxt;
    end
  end

  assign mcu_grant = (state == ARB_STATE_GRANT_MCU);
  assign cop_grant = (state == ARB_STATE_GRANT_COP);
  assign bus_idle  = (state == ARB_STATE_IDLE) || (state == ARB_STATE_GUARD);

endmodule
